// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared state encodings and default parameters for the ALU sequencer
package alu_sequencer_pkg;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OP  = 2'd2,
        S_RES = 2'd3
    } state_t;

    localparam int DEFAULT_BUS_WIDTH       = 16;
    localparam int DEFAULT_OP_WIDTH        = 6;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - front panel and ALU signal bundle of the ALU sequencer
interface alu_sequencer_if #(
    parameter int BUS_WIDTH = 16,
    parameter int OP_WIDTH  = 6
);

    logic [BUS_WIDTH-1:0] i_switches;
    logic                 i_button;
    logic                 i_clear;
    logic [BUS_WIDTH-1:0] i_alu_result;
    logic [BUS_WIDTH-1:0] o_dato_a;
    logic [BUS_WIDTH-1:0] o_dato_b;
    logic [OP_WIDTH-1:0]  o_opcode;
    logic [BUS_WIDTH-1:0] o_result;
    logic                 o_valid;
    logic [1:0]           o_state;

    // Sequencer side: consumes panel inputs and the ALU result, drives operands and LEDs
    modport slave (
        input  i_switches,
        input  i_button,
        input  i_clear,
        input  i_alu_result,
        output o_dato_a,
        output o_dato_b,
        output o_opcode,
        output o_result,
        output o_valid,
        output o_state
    );

    // Panel/ALU side: the mirror image of the sequencer
    modport master (
        output i_switches,
        output i_button,
        output i_clear,
        output i_alu_result,
        input  o_dato_a,
        input  o_dato_b,
        input  o_opcode,
        input  o_result,
        input  o_valid,
        input  o_state
    );

endinterface

// File: rtl/alu_sequencer_debouncer.sv
// rtl/alu_sequencer_debouncer.sv - synchronizer, stability counter and press pulse for the enter button
import alu_sequencer_pkg::*;

module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer for the raw asynchronous button
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= i_raw;
            s2 <= s1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            o_level <= 1'b0;
            o_press <= 1'b0;
        end else begin
            o_press <= 1'b0;
            if (s2 != o_level) begin
                if (cnt == CNT_LAST) begin
                    cnt     <= '0;
                    o_level <= s2;
                    o_press <= s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - single-button operand/opcode entry FSM driving the switch ALU
import alu_sequencer_pkg::*;

module alu_sequencer #(
    parameter int BUS_WIDTH       = DEFAULT_BUS_WIDTH,
    parameter int OP_WIDTH        = DEFAULT_OP_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    alu_sequencer_if.slave  bus
);

    state_t state_q;
    state_t state_d;

    logic btn_level;
    logic btn_press;
    logic press;

    logic load_a;
    logic load_b;
    logic load_op;
    logic capture;
    logic valid_clr;

    logic [BUS_WIDTH-1:0] dato_a_q;
    logic [BUS_WIDTH-1:0] dato_b_q;
    logic [OP_WIDTH-1:0]  opcode_q;
    logic [BUS_WIDTH-1:0] result_q;
    logic                 valid_q;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk     (clk),
        .reset   (reset),
        .i_raw   (bus.i_button),
        .o_level (btn_level),
        .o_press (btn_press)
    );

    // The pulse is only raised on a rising accepted level, so qualifying with the level is belt and braces
    assign press = btn_press & btn_level;

    // Next state and load strobes; clear outranks a coincident press
    always_comb begin
        state_d   = state_q;
        load_a    = 1'b0;
        load_b    = 1'b0;
        load_op   = 1'b0;
        capture   = 1'b0;
        valid_clr = 1'b0;
        if (bus.i_clear) begin
            state_d   = S_A;
            valid_clr = 1'b1;
        end else begin
            case (state_q)
                S_A: begin
                    if (press) begin
                        load_a    = 1'b1;
                        valid_clr = 1'b1;
                        state_d   = S_B;
                    end
                end
                S_B: begin
                    if (press) begin
                        load_b  = 1'b1;
                        state_d = S_OP;
                    end
                end
                S_OP: begin
                    if (press) begin
                        load_op = 1'b1;
                        state_d = S_RES;
                    end
                end
                S_RES: begin
                    if (press) begin
                        valid_clr = 1'b1;
                        state_d   = S_A;
                    end else begin
                        capture = 1'b1;
                    end
                end
                default: state_d = S_A;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, opcode and result registers; each changes only on its own strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dato_a_q <= '0;
            dato_b_q <= '0;
            opcode_q <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (load_a) begin
                dato_a_q <= bus.i_switches;
            end
            if (load_b) begin
                dato_b_q <= bus.i_switches;
            end
            if (load_op) begin
                opcode_q <= bus.i_switches[OP_WIDTH-1:0];
            end
            if (capture) begin
                result_q <= bus.i_alu_result;
                valid_q  <= 1'b1;
            end else if (valid_clr) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.o_dato_a = dato_a_q;
    assign bus.o_dato_b = dato_b_q;
    assign bus.o_opcode = opcode_q;
    assign bus.o_result = result_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_state  = state_q;

endmodule
